// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared constants, state encoding and helpers for main_memory_model
package mem_pkg;

    localparam int LINE_W_DEF = 128;
    localparam int ADDR_W_DEF = 32;
    localparam int OFFS_W     = 4;
    localparam int CNT_W      = 16;

    typedef enum logic [1:0] {
        MEM_IDLE,
        MEM_BUSY,
        MEM_DRAIN
    } mem_state_e;

    // Completion counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/mem_line_array.sv
// rtl/mem_line_array.sv - DEPTH x LINE_W line storage, synchronous write, registered read
module mem_line_array #(
    parameter int DEPTH  = 1024,
    parameter int LINE_W = 128,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [LINE_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [LINE_W-1:0] rdata
);

    logic [LINE_W-1:0] mem [DEPTH];

    // Plain RAM: no reset, so contents survive a controller reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/main_memory_model.sv
// rtl/main_memory_model.sv - line-granular backing memory with programmable access latency
module main_memory_model
    import mem_pkg::*;
#(
    parameter int LINE_W  = LINE_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] mem_req_addr,
    input  logic [LINE_W-1:0] mem_req_dataout,
    input  logic              mem_req_rw,
    input  logic              mem_req_valid,
    output logic [LINE_W-1:0] mem_req_datain,
    output logic              mem_req_ready,
    output logic [CNT_W-1:0]  rd_count,
    output logic [CNT_W-1:0]  wr_count
);

    localparam int IDX_W = $clog2(DEPTH);

    mem_state_e        state;
    mem_state_e        next_state;
    logic [7:0]        lat_cnt;
    logic [IDX_W-1:0]  cap_idx;
    logic              cap_rw;
    logic [LINE_W-1:0] cap_data;
    logic [LINE_W-1:0] arr_rdata;
    logic [LINE_W-1:0] datain_q;
    logic [CNT_W-1:0]  rd_cnt;
    logic [CNT_W-1:0]  wr_cnt;

    logic [IDX_W-1:0]  req_idx;
    logic [IDX_W-1:0]  arr_raddr;
    logic              accept;
    logic              commit;
    logic              arr_we;

    // Offset and upper address bits are intentionally dropped; lines alias modulo DEPTH.
    logic              unused_addr;
    assign unused_addr = ^{mem_req_addr[ADDR_W-1:OFFS_W+IDX_W], mem_req_addr[OFFS_W-1:0]};

    assign req_idx = mem_req_addr[OFFS_W +: IDX_W];
    assign accept  = (state == MEM_IDLE) && mem_req_valid;
    // Commit on the edge where the latency counter steps from 1 to 0.
    assign commit  = (state == MEM_BUSY) && (lat_cnt == 8'd1);
    assign arr_we  = commit && cap_rw && !rst;
    // Point the read port at the incoming index while idle so the line is
    // already registered in the array by the first BUSY cycle, even with LATENCY=1.
    assign arr_raddr = (state == MEM_IDLE) ? req_idx : cap_idx;

    mem_line_array #(
        .DEPTH  (DEPTH),
        .LINE_W (LINE_W),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .waddr (cap_idx),
        .wdata (cap_data),
        .raddr (arr_raddr),
        .rdata (arr_rdata)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= MEM_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state: accept once, count down, then wait for valid to drop.
    always_comb begin
        next_state = state;
        case (state)
            MEM_IDLE:  if (mem_req_valid) next_state = MEM_BUSY;
            MEM_BUSY:  if (lat_cnt == 8'd1) next_state = MEM_DRAIN;
            MEM_DRAIN: if (!mem_req_valid) next_state = MEM_IDLE;
            default:   next_state = MEM_IDLE;
        endcase
    end

    // Request capture; only the captured copy is used once BUSY.
    always_ff @(posedge clk) begin
        if (accept) begin
            cap_idx  <= req_idx;
            cap_rw   <= mem_req_rw;
            cap_data <= mem_req_dataout;
        end
    end

    // Latency counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_cnt <= 8'd0;
        end else if (accept) begin
            lat_cnt <= 8'(LATENCY);
        end else if (state == MEM_BUSY) begin
            lat_cnt <= lat_cnt - 8'd1;
        end
    end

    // Read data register; holds until the next read completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            datain_q <= '0;
        end else if (commit && !cap_rw) begin
            datain_q <= arr_rdata;
        end
    end

    // Saturating completion counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt <= '0;
            wr_cnt <= '0;
        end else if (commit) begin
            if (cap_rw) begin
                wr_cnt <= sat_inc(wr_cnt);
            end else begin
                rd_cnt <= sat_inc(rd_cnt);
            end
        end
    end

    assign mem_req_ready  = (state == MEM_IDLE);
    assign mem_req_datain = datain_q;
    assign rd_count       = rd_cnt;
    assign wr_count       = wr_cnt;

endmodule

// File: tb/tb_main_memory_model.sv
// tb/tb_main_memory_model.sv - randomized self-checking bench for main_memory_model
module tb_main_memory_model;

    localparam int LAT = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  addr;
    logic [127:0] dataout;
    logic         rw;
    logic         valid;
    logic [127:0] datain;
    logic         ready;
    logic [15:0]  rd_count;
    logic [15:0]  wr_count;

    int checks = 0;
    int errors = 0;

    logic [127:0] model_mem [int];
    logic [127:0] model_datain;
    int           model_rd;
    int           model_wr;

    main_memory_model #(
        .LINE_W  (128),
        .ADDR_W  (32),
        .DEPTH   (1024),
        .LATENCY (LAT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .mem_req_addr    (addr),
        .mem_req_dataout (dataout),
        .mem_req_rw      (rw),
        .mem_req_valid   (valid),
        .mem_req_datain  (datain),
        .mem_req_ready   (ready),
        .rd_count        (rd_count),
        .wr_count        (wr_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int line_of(input logic [31:0] a);
        return int'(a / 16) % 1024;
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, "_datain"}, datain, model_datain);
        check({tag, "_rd"}, rd_count, 128'(model_rd));
        check({tag, "_wr"}, wr_count, 128'(model_wr));
    endtask

    // One request; valid is held for 'hold' accepting edges, inputs optionally scrambled after acceptance.
    task automatic do_req(input logic w, input logic [31:0] a, input logic [127:0] d,
                          input int hold, input bit scramble, input string tag);
        int low;
        int held;
        int budget;
        int exp_low;
        @(negedge clk);
        check({tag, "_ready_pre"}, ready, 1);
        rw = w; addr = a; dataout = d; valid = 1'b1;
        @(posedge clk);
        held = 1; low = 0; budget = 0;
        while (budget < 200) begin
            @(negedge clk);
            budget++;
            if (ready) break;
            low++;
            if (held >= hold) valid = 1'b0;
            if (scramble) begin
                addr = $urandom;
                dataout = {$urandom, $urandom, $urandom, $urandom};
                rw = 1'($urandom);
            end
            @(posedge clk);
            held++;
        end
        valid = 1'b0;
        check({tag, "_ready_post"}, ready, 1);
        exp_low = (hold > LAT + 1) ? hold : LAT + 1;
        check({tag, "_low_cycles"}, 128'(low), 128'(exp_low));
        if (w) begin
            model_mem[line_of(a)] = d;
            if (model_wr < 65535) model_wr++;
        end else begin
            model_datain = model_mem[line_of(a)];
            if (model_rd < 65535) model_rd++;
        end
        check_outputs(tag);
    endtask

    initial begin
        logic [31:0] ra;
        logic        rwr;
        int          li;

        rst = 1'b1; valid = 1'b0; rw = 1'b0; addr = '0; dataout = '0;
        model_datain = '0; model_rd = 0; model_wr = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_ready", ready, 1);
        check_outputs("reset");

        do_req(1'b1, 32'h0000AB00, 128'h1122, 1, 1'b0, "wr_ab00");
        do_req(1'b0, 32'h0000AB00, 128'h0, 1, 1'b0, "rd_ab00");

        do_req(1'b1, 32'h0000BB00, 128'h3344, 1, 1'b0, "wr_bb00");
        do_req(1'b0, 32'h0000BB00, 128'h0, 6, 1'b0, "rd_bb00_held");

        do_req(1'b1, 32'h0000EB04, 128'h5566, 1, 1'b0, "wr_eb04");
        do_req(1'b0, 32'h0040EB00, 128'h0, 1, 1'b0, "rd_alias");

        for (int i = 0; i < 40; i++) begin
            li  = $urandom_range(0, 7) * 37;
            ra  = $urandom;
            ra[13:4] = 10'(li);
            rwr = 1'($urandom);
            if (!rwr && !model_mem.exists(li)) rwr = 1'b1;
            do_req(rwr, ra, {$urandom, $urandom, $urandom, $urandom},
                   $urandom_range(1, 5), 1'b1, $sformatf("rand%0d", i));
        end

        // Reset during the second BUSY cycle of a write, with valid also asserted during reset.
        @(negedge clk);
        rw = 1'b1; addr = 32'h0000AB00; dataout = 128'h7788; valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        check("midbusy_ready_low", ready, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1; valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; valid = 1'b0;
        check("midbusy_ready", ready, 1);
        model_rd = 0; model_wr = 0; model_datain = '0;
        check_outputs("midbusy");
        do_req(1'b0, 32'h0000AB00, 128'h0, 1, 1'b0, "rd_after_abort");

        // Saturation: preload the read counter just below its ceiling.
        @(negedge clk);
        dut.rd_cnt = 16'hFFFE;
        model_rd = 65534;
        for (int i = 0; i < 3; i++) begin
            do_req(1'b0, 32'h0000BB00, 128'h0, 1, 1'b0, $sformatf("sat%0d", i));
        end
        check("sat_final", rd_count, 16'hFFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
